// File: rtl/sseg_pkg.sv
// Shared types for the sign-magnitude display stage: digit codes, FSM states
// and the active-low seven-segment encoder.
package sseg_pkg;

  typedef enum logic [3:0] {
    DIG_0, DIG_1, DIG_2, DIG_3, DIG_4,
    DIG_5, DIG_6, DIG_7, DIG_8, DIG_9,
    DIG_MINUS, DIG_BLANK
  } digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  // Segment patterns are {dp,g,f,e,d,c,b,a}, active-low; dp is always off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] encode(input digit_t d);
    case (d)
      DIG_0:     encode = SEG_0;
      DIG_1:     encode = SEG_1;
      DIG_2:     encode = SEG_2;
      DIG_3:     encode = SEG_3;
      DIG_4:     encode = SEG_4;
      DIG_5:     encode = SEG_5;
      DIG_6:     encode = SEG_6;
      DIG_7:     encode = SEG_7;
      DIG_8:     encode = SEG_8;
      DIG_9:     encode = SEG_9;
      DIG_MINUS: encode = SEG_MINUS;
      default:   encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle for MAG_W cycles,
// producing two BCD digits (magnitude never exceeds 63).
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int MAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAG_W-1:0] bin,
  output logic             done,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  localparam int CW = $clog2(MAG_W + 1);

  logic [CW-1:0]    cnt;
  logic [7:0]       bcd;
  logic [7:0]       bcd_adj;
  logic [MAG_W-1:0] shreg;

  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      bcd   <= '0;
      shreg <= '0;
    end else if (start) begin
      cnt   <= CW'(MAG_W);
      bcd   <= '0;
      shreg <= bin;
    end else if (cnt != '0) begin
      {bcd, shreg} <= {bcd_adj, shreg} << 1;
      cnt          <= cnt - CW'(1);
    end
  end

  // High during the final step, so the caller can leave CONV on that same edge.
  assign done = (cnt == CW'(1));
  assign tens = bcd[7:4];
  assign ones = bcd[3:0];

endmodule

// File: rtl/sign_mag_sseg_disp.sv
// Display stage: accepts a sign-magnitude result, converts it to BCD and scans
// it onto a 4-digit multiplexed active-low seven-segment display.
module sign_mag_sseg_disp
  import sseg_pkg::*;
#(
  parameter int MAG_W        = 4,
  parameter int REFRESH_W    = 16,
  parameter int BLANK_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [MAG_W-1:0] in_mag,
  output logic [3:0]       an,
  output logic [7:0]       sseg
);

  localparam logic [REFRESH_W-1:0] BLANK_LIM = REFRESH_W'(BLANK_CYCLES);

  state_t state, next_state;
  logic   conv_start;
  logic   conv_done;
  logic   load_en;
  logic   neg_r;
  logic [3:0] tens;
  logic [3:0] ones;
  digit_t dig [4];

  logic [REFRESH_W-1:0] refresh_cnt;
  logic [1:0]           slot;

  bin2bcd_seq #(
    .MAG_W (MAG_W)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (in_mag),
    .done  (conv_done),
    .tens  (tens),
    .ones  (ones)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    conv_start = 1'b0;
    load_en    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          conv_start = 1'b1;
          next_state = CONV;
        end
      end
      CONV: begin
        if (conv_done) next_state = LOAD;
      end
      LOAD: begin
        load_en    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Negative zero is shown as a plain "0", so the minus flag needs a nonzero magnitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_r  <= 1'b0;
      dig[0] <= DIG_0;
      dig[1] <= DIG_BLANK;
      dig[2] <= DIG_BLANK;
      dig[3] <= DIG_BLANK;
    end else begin
      if (conv_start) neg_r <= in_sign && (in_mag != '0);
      if (load_en) begin
        dig[0] <= digit_t'(ones);
        if (tens != 4'd0) begin
          dig[1] <= digit_t'(tens);
          dig[2] <= neg_r ? DIG_MINUS : DIG_BLANK;
        end else begin
          dig[1] <= neg_r ? DIG_MINUS : DIG_BLANK;
          dig[2] <= DIG_BLANK;
        end
        dig[3] <= DIG_BLANK;
      end
    end
  end

  // Each slot opens with a few dark cycles so the previous digit cannot ghost.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      slot        <= 2'd0;
      an          <= 4'hF;
      sseg        <= SEG_BLANK;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_W'(1);
      if (refresh_cnt == '1) slot <= slot + 2'd1;
      if (refresh_cnt < BLANK_LIM) begin
        an   <= 4'hF;
        sseg <= SEG_BLANK;
      end else begin
        an   <= ~(4'b0001 << slot);
        sseg <= encode(dig[slot]);
      end
    end
  end

endmodule

// File: tb/tb_sign_mag_sseg_disp.sv
// Self-checking bench for sign_mag_sseg_disp: scoreboard of display updates
// plus observation of the scanned anode/segment outputs.
module tb_sign_mag_sseg_disp;
  import sseg_pkg::*;

  localparam int MAG_W        = 4;
  localparam int REFRESH_W    = 3;
  localparam int BLANK_CYCLES = 2;

  localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [31:0] RESET_DISP = 32'hFFFF_FFC0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sign = 1'b0;
  logic [MAG_W-1:0] in_mag = '0;
  logic [3:0]       an;
  logic [7:0]       sseg;

  int assert_count = 0;
  int fail_count   = 0;
  int cyc          = 0;
  int accept_count = 0;

  typedef struct {
    logic [31:0] disp;
    int          accept_cyc;
  } sb_entry_t;

  sb_entry_t sb_q [$];
  sb_entry_t sb_e;
  logic      prev_ready = 1'b1;

  sign_mag_sseg_disp #(
    .MAG_W        (MAG_W),
    .REFRESH_W    (REFRESH_W),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sign  (in_sign),
    .in_mag   (in_mag),
    .an       (an),
    .sseg     (sseg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_disp(input logic s, input logic [MAG_W-1:0] m);
    int t, o;
    logic neg;
    logic [7:0] d1, d2;
    t   = int'(m) / 10;
    o   = int'(m) % 10;
    neg = s && (m != '0);
    d1  = (t != 0) ? SEG_TBL[t] : (neg ? 8'hBF : 8'hFF);
    d2  = (neg && t != 0) ? 8'hBF : 8'hFF;
    return {8'hFF, d2, d1, SEG_TBL[o]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Acceptance is sampled in the active region of the edge, before state updates.
  always @(posedge clk) begin
    cyc++;
    if (rst) sb_q.delete();
    else if (in_valid && in_ready) begin
      sb_q.push_back('{model_disp(in_sign, in_mag), cyc});
      accept_count++;
    end
  end

  always @(negedge clk) begin
    if (!rst && in_ready && !prev_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected_update", 32'(sb_q.size()), 32'd1);
      end else begin
        sb_e = sb_q.pop_front();
        checkOutput("disp_regs", {encode(dut.dig[3]), encode(dut.dig[2]),
                                  encode(dut.dig[1]), encode(dut.dig[0])}, sb_e.disp);
        checkOutput("latency", 32'(cyc - sb_e.accept_cyc), 32'(MAG_W + 1));
      end
    end
    prev_ready = in_ready;
  end

  task automatic checkScan(input string tag, input logic [31:0] expected);
    logic [31:0] seen_disp;
    logic [3:0]  seen;
    int          bad;
    seen_disp = '1;
    seen      = '0;
    bad       = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin seen_disp[7:0]   = sseg; seen[0] = 1'b1; end
        4'b1101: begin seen_disp[15:8]  = sseg; seen[1] = 1'b1; end
        4'b1011: begin seen_disp[23:16] = sseg; seen[2] = 1'b1; end
        4'b0111: begin seen_disp[31:24] = sseg; seen[3] = 1'b1; end
        4'b1111: if (sseg != 8'hFF) bad++;
        default: bad++;
      endcase
    end
    checkOutput({tag, "_slots"}, 32'(seen), 32'hF);
    checkOutput({tag, "_blank"}, 32'(bad), 32'd0);
    checkOutput({tag, "_digits"}, seen_disp, expected);
  endtask

  task automatic applyStimulus(input logic s, input logic [MAG_W-1:0] m);
    int start, waited, low_cycles;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_sign  = s;
    in_mag   = m;
    start    = accept_count;
    waited   = 0;
    while (accept_count == start && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept_seen", 32'(accept_count - start), 32'd1);
    #1 in_valid = 1'b0;
    low_cycles = 0;
    while (!in_ready && low_cycles < 20) begin
      low_cycles++;
      @(negedge clk);
    end
    checkOutput("ready_low_cycles", 32'(low_cycles), 32'(MAG_W + 1));
  endtask

  initial begin
    int start, w;

    repeat (4) @(negedge clk);
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_sseg", 32'(sseg), 32'hFF);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("blank0_an", 32'(an), 32'hF);
    @(negedge clk);
    checkOutput("blank1_sseg", 32'(sseg), 32'hFF);
    @(negedge clk);
    checkOutput("slot0_an", 32'(an), 32'hE);
    checkOutput("slot0_sseg", 32'(sseg), 32'hC0);
    repeat (8) @(negedge clk);
    checkOutput("slot1_an", 32'(an), 32'hD);
    checkOutput("slot1_sseg", 32'(sseg), 32'hFF);
    checkScan("rst_scan", RESET_DISP);

    applyStimulus(1'b0, 4'd5);
    checkScan("pos5", model_disp(1'b0, 4'd5));
    applyStimulus(1'b1, 4'd14);
    checkScan("neg14", model_disp(1'b1, 4'd14));
    applyStimulus(1'b1, 4'd7);
    checkScan("neg7", model_disp(1'b1, 4'd7));
    applyStimulus(1'b1, 4'd0);
    checkScan("negzero", model_disp(1'b1, 4'd0));
    applyStimulus(1'b0, 4'd15);
    checkScan("pos15", model_disp(1'b0, 4'd15));
    applyStimulus(1'b0, 4'd10);
    checkScan("pos10", model_disp(1'b0, 4'd10));

    // Backpressure: the second value must wait for the first conversion to finish.
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_mag   = 4'd3;
    start    = accept_count;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_hold_ready", 32'(in_ready), 32'd0);
    #1 in_mag = 4'd9;
    w = 0;
    while (accept_count < start + 2 && w < 30) begin
      @(negedge clk);
      w++;
    end
    checkOutput("bp_accepts", 32'(accept_count - start), 32'd2);
    #1 in_valid = 1'b0;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("bp_ready", 32'(in_ready), 32'd1);
    checkScan("bp9", model_disp(1'b0, 4'd9));

    // Reset during conversion must discard the value in flight.
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_mag   = 4'd12;
    start    = accept_count;
    @(negedge clk);
    checkOutput("midrst_accept", 32'(accept_count - start), 32'd1);
    #1 in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;
    checkScan("midrst_scan", RESET_DISP);
    checkOutput("midrst_ready_after", 32'(in_ready), 32'd1);

    checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
